rv32i_seq_ctrl: RTL and testbench

//  Multi-cycle sequencer for the RV32I core. Fetches an instruction over a req/valid handshake and holds it in
//  the instruction register (IR). Drives immed_gen (field = IR[31:7], select = IR[6:5]) and steps the

---
 rtl/rv32i_seq_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_rv32i_seq_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core.
// Optional macro ILLEGAL_TRAP_EN: unsupported opcodes trap (terminal) instead of executing as NOP.
module rv32i_seq_ctrl #(
    parameter logic [31:0] RESET_INSTR = 32'h0000_0013,
    parameter int unsigned TIMEOUT_W   = 8,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic        imem_req,
    output logic [24:0] imm_field,
    output logic [1:0]  imm_select,
    output logic        alu_src_imm,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        rf_we,
    output logic        pc_en,
    output logic        bus_err,
    output logic        illegal,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [TIMEOUT_W-1:0] CNT_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    localparam logic [TIMEOUT_W:0]   TMO_VAL = MEM_TIMEOUT[TIMEOUT_W:0];
    localparam logic                 TMO_EN  = (MEM_TIMEOUT != 32'd0);

    function automatic logic op_supported(input logic [6:0] opc);
        case (opc)
            OPC_LOAD, OPC_OPIMM, OPC_STORE, OPC_OP, OPC_BRANCH: op_supported = 1'b1;
            default:                                            op_supported = 1'b0;
        endcase
    endfunction

    function automatic logic op_mem(input logic [6:0] opc);
        case (opc)
            OPC_LOAD, OPC_STORE: op_mem = 1'b1;
            default:             op_mem = 1'b0;
        endcase
    endfunction

    function automatic logic op_writes_rf(input logic [6:0] opc);
        case (opc)
            OPC_LOAD, OPC_OPIMM, OPC_OP: op_writes_rf = 1'b1;
            default:                     op_writes_rf = 1'b0;
        endcase
    endfunction

    function automatic logic op_uses_imm(input logic [6:0] opc);
        case (opc)
            OPC_LOAD, OPC_OPIMM, OPC_STORE: op_uses_imm = 1'b1;
            default:                        op_uses_imm = 1'b0;
        endcase
    endfunction

    state_t               state_q, state_d;
    logic [31:0]          ir_q, ir_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 tmo_q, tmo_d;
    logic                 bus_err_q, bus_err_d;
    logic                 alu_imm_q, alu_imm_d;
    logic                 imem_req_q, imem_req_d;
    logic                 dmem_req_q, dmem_req_d;
    logic                 dmem_we_q, dmem_we_d;
    logic                 rf_we_q, rf_we_d;
    logic                 pc_en_q, pc_en_d;
`ifdef ILLEGAL_TRAP_EN
    logic                 illegal_q, illegal_d;
`endif

    // Next-state logic; outputs are precomputed from the next state so they register with it.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        bus_err_d = bus_err_q;
        alu_imm_d = alu_imm_q;
`ifdef ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        if (stall) begin
            state_d = state_q;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_valid) begin
                        ir_d      = imem_rdata;
                        alu_imm_d = op_uses_imm(imem_rdata[6:0]);
                        tmo_d     = 1'b0;
                        state_d   = S_DECODE;
                    end else begin
                        state_d   = S_FETCH;
                    end
                end
                S_DECODE: begin
                    if (op_supported(ir_q[6:0])) begin
                        state_d = S_EXEC;
                    end else begin
`ifdef ILLEGAL_TRAP_EN
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                        alu_imm_d = 1'b0;
`else
                        state_d   = S_WB;
`endif
                    end
                end
                S_EXEC: begin
                    if (op_mem(ir_q[6:0])) begin
                        state_d = S_MEM;
                    end else begin
                        state_d = S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        cnt_d   = {TIMEOUT_W{1'b0}};
                        state_d = S_WB;
                    end else if (TMO_EN && (({1'b0, cnt_q} + {1'b0, CNT_ONE}) == TMO_VAL)) begin
                        cnt_d     = {TIMEOUT_W{1'b0}};
                        tmo_d     = 1'b1;
                        bus_err_d = 1'b1;
                        state_d   = S_WB;
                    end else begin
                        cnt_d   = cnt_q + CNT_ONE;
                        state_d = S_MEM;
                    end
                end
                S_WB: begin
                    state_d = S_FETCH;
                end
`ifdef ILLEGAL_TRAP_EN
                S_TRAP: begin
                    state_d = S_TRAP;
                end
`endif
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end

        imem_req_d = (state_d == S_FETCH);
        dmem_req_d = (state_d == S_MEM);
        dmem_we_d  = (state_d == S_MEM) && (ir_d[6:0] == OPC_STORE);
        pc_en_d    = (state_d == S_WB);
        rf_we_d    = (state_d == S_WB) && op_writes_rf(ir_d[6:0]) && !tmo_d;
    end

    // State and registered outputs; async reset aborts any instruction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_FETCH;
            ir_q       <= RESET_INSTR;
            cnt_q      <= {TIMEOUT_W{1'b0}};
            tmo_q      <= 1'b0;
            bus_err_q  <= 1'b0;
            alu_imm_q  <= 1'b0;
            imem_req_q <= 1'b1;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            rf_we_q    <= 1'b0;
            pc_en_q    <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            bus_err_q  <= bus_err_d;
            alu_imm_q  <= alu_imm_d;
            imem_req_q <= imem_req_d;
            dmem_req_q <= dmem_req_d;
            dmem_we_q  <= dmem_we_d;
            rf_we_q    <= rf_we_d;
            pc_en_q    <= pc_en_d;
`ifdef ILLEGAL_TRAP_EN
            illegal_q  <= illegal_d;
`endif
        end
    end

    assign imem_req    = imem_req_q;
    assign imm_field   = ir_q[31:7];
    assign imm_select  = ir_q[6:5];
    assign alu_src_imm = alu_imm_q;
    assign dmem_req    = dmem_req_q;
    assign dmem_we     = dmem_we_q;
    assign rf_we       = rf_we_q;
    assign pc_en       = pc_en_q;
    assign bus_err     = bus_err_q;
    assign state       = state_q;
`ifdef ILLEGAL_TRAP_EN
    assign illegal     = illegal_q;
`else
    assign illegal     = 1'b0;
`endif

endmodule

// File: tb/tb_rv32i_seq_ctrl.sv
// Directed bench for rv32i_seq_ctrl (MEM_TIMEOUT=4): fetch/decode flow, MEM waits, timeout, stall, reset abort.
module tb_rv32i_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic        imem_req;
    logic [24:0] imm_field;
    logic [1:0]  imm_select;
    logic        alu_src_imm;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    logic        rf_we;
    logic        pc_en;
    logic        bus_err;
    logic        illegal;
    logic [2:0]  state;

    int n_checks = 0;
    int n_fail   = 0;

    rv32i_seq_ctrl #(
        .RESET_INSTR (32'h0000_0013),
        .TIMEOUT_W   (8),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .imem_req    (imem_req),
        .imm_field   (imm_field),
        .imm_select  (imm_select),
        .alu_src_imm (alu_src_imm),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_ready  (dmem_ready),
        .rf_we       (rf_we),
        .pc_en       (pc_en),
        .bus_err     (bus_err),
        .illegal     (illegal),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst        = 1'b1;
        stall      = 1'b0;
        imem_rdata = 32'h0;
        imem_valid = 1'b0;
        dmem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // reset / idle
        chk("rst_state",    32'(state),      32'd0);
        chk("rst_imem_req", 32'(imem_req),   32'd1);
        chk("rst_field",    32'(imm_field),  32'd0);
        chk("rst_select",   32'(imm_select), 32'd0);
        chk("rst_rf_we",    32'(rf_we),      32'd0);
        chk("rst_pc_en",    32'(pc_en),      32'd0);
        chk("rst_alu_imm",  32'(alu_src_imm), 32'd0);
        chk("rst_bus_err",  32'(bus_err),    32'd0);

        // addi x1,x0,5
        imem_rdata = 32'h0050_0093;
        imem_valid = 1'b1;
        tick();
        imem_valid = 1'b0;
        chk("addi_state_dec", 32'(state),       32'd1);
        chk("addi_field",     32'(imm_field),   32'h000_A001);
        chk("addi_select",    32'(imm_select),  32'd0);
        chk("addi_alu_imm",   32'(alu_src_imm), 32'd1);
        chk("addi_imem_req",  32'(imem_req),    32'd0);
        tick();
        chk("addi_state_ex",  32'(state),       32'd2);
        chk("addi_pc_en_early", 32'(pc_en),     32'd0);
        tick();
        chk("addi_state_wb",  32'(state),       32'd4);
        chk("addi_pc_en",     32'(pc_en),       32'd1);
        chk("addi_rf_we",     32'(rf_we),       32'd1);
        tick();
        chk("addi_state_ret", 32'(state),       32'd0);
        chk("addi_pc_en_end", 32'(pc_en),       32'd0);
        chk("addi_rf_we_end", 32'(rf_we),       32'd0);

        // sw with two wait cycles, valid ignored while in MEM
        imem_rdata = 32'h0020_A223;
        imem_valid = 1'b1;
        tick();
        imem_valid = 1'b0;
        chk("sw_select",      32'(imm_select),  32'd1);
        chk("sw_alu_imm",     32'(alu_src_imm), 32'd1);
        tick();
        chk("sw_state_ex",    32'(state),       32'd2);
        chk("sw_dmem_req_ex", 32'(dmem_req),    32'd0);
        tick();
        chk("sw_mem1_req",    32'(dmem_req),    32'd1);
        chk("sw_mem1_we",     32'(dmem_we),     32'd1);
        imem_valid = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        tick();
        imem_valid = 1'b0;
        chk("sw_mem2_req",    32'(dmem_req),    32'd1);
        chk("sw_field_hold",  32'(imm_field),   32'h000_4144);
        tick();
        chk("sw_mem3_req",    32'(dmem_req),    32'd1);
        chk("sw_mem3_state",  32'(state),       32'd3);
        dmem_ready = 1'b1;
        tick();
        dmem_ready = 1'b0;
        chk("sw_wb_state",    32'(state),       32'd4);
        chk("sw_wb_pc_en",    32'(pc_en),       32'd1);
        chk("sw_wb_rf_we",    32'(rf_we),       32'd0);
        chk("sw_wb_dmem_req", 32'(dmem_req),    32'd0);
        chk("sw_wb_dmem_we",  32'(dmem_we),     32'd0);
        tick();

        // lw with no ready -> timeout after 4 MEM cycles
        imem_rdata = 32'h0000_A083;
        imem_valid = 1'b1;
        tick();
        imem_valid = 1'b0;
        tick();
        tick();
        chk("lw_mem1_state",  32'(state),       32'd3);
        chk("lw_mem1_we",     32'(dmem_we),     32'd0);
        tick();
        tick();
        tick();
        chk("lw_mem4_state",  32'(state),       32'd3);
        chk("lw_mem4_buserr", 32'(bus_err),     32'd0);
        tick();
        chk("lw_to_state",    32'(state),       32'd4);
        chk("lw_to_buserr",   32'(bus_err),     32'd1);
        chk("lw_to_rf_we",    32'(rf_we),       32'd0);
        chk("lw_to_pc_en",    32'(pc_en),       32'd1);
        tick();
        chk("lw_ret_state",   32'(state),       32'd0);
        chk("lw_sticky_err",  32'(bus_err),     32'd1);

        // beq, stalled 3 cycles in EXEC
        imem_rdata = 32'h0000_0463;
        imem_valid = 1'b1;
        tick();
        imem_valid = 1'b0;
        chk("beq_select",     32'(imm_select),  32'd3);
        chk("beq_alu_imm",    32'(alu_src_imm), 32'd0);
        tick();
        stall = 1'b1;
        tick();
        chk("beq_stall1",     32'(state),       32'd2);
        tick();
        chk("beq_stall2",     32'(state),       32'd2);
        tick();
        chk("beq_stall3",     32'(state),       32'd2);
        chk("beq_stall_pc",   32'(pc_en),       32'd0);
        stall = 1'b0;
        tick();
        chk("beq_wb_pc_en",   32'(pc_en),       32'd1);
        chk("beq_wb_rf_we",   32'(rf_we),       32'd0);
        tick();

        // stall wins over imem_valid; LUI then decoded
        stall      = 1'b1;
        imem_rdata = 32'h0000_0037;
        imem_valid = 1'b1;
        tick();
        chk("lui_stall_state", 32'(state),      32'd0);
        chk("lui_stall_field", 32'(imm_field),  32'h000_0008);
        stall = 1'b0;
        tick();
        imem_valid = 1'b0;
        chk("lui_dec_state",  32'(state),       32'd1);
        chk("lui_select",     32'(imm_select),  32'd1);
        tick();
`ifdef ILLEGAL_TRAP_EN
        chk("lui_trap_state", 32'(state),       32'd5);
        chk("lui_illegal",    32'(illegal),     32'd1);
        chk("lui_trap_pc_en", 32'(pc_en),       32'd0);
        tick();
        chk("lui_trap_hold",  32'(state),       32'd5);
        chk("lui_trap_req",   32'(imem_req),    32'd0);
        chk("lui_trap_pc2",   32'(pc_en),       32'd0);
`else
        chk("lui_nop_state",  32'(state),       32'd4);
        chk("lui_nop_pc_en",  32'(pc_en),       32'd1);
        chk("lui_nop_rf_we",  32'(rf_we),       32'd0);
        chk("lui_nop_illegal", 32'(illegal),    32'd0);
        tick();
`endif

        // reset aborts add in EXEC and clears sticky flags
        rst = 1'b1;
        #1;
        rst = 1'b0;
        tick();
        imem_rdata = 32'h0020_81B3;
        imem_valid = 1'b1;
        tick();
        imem_valid = 1'b0;
        chk("add_alu_imm",    32'(alu_src_imm), 32'd0);
        tick();
        chk("add_state_ex",   32'(state),       32'd2);
        rst = 1'b1;
        #1;
        chk("abort_state",    32'(state),       32'd0);
        chk("abort_pc_en",    32'(pc_en),       32'd0);
        chk("abort_buserr",   32'(bus_err),     32'd0);
        chk("abort_illegal",  32'(illegal),     32'd0);
        chk("abort_field",    32'(imm_field),   32'd0);
        rst = 1'b0;
        tick();
        tick();
        chk("abort_no_pc_en", 32'(pc_en),       32'd0);
        chk("abort_no_rf_we", 32'(rf_we),       32'd0);
        chk("abort_idle",     32'(state),       32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
